// File: rtl/integrator_arbiter_pkg.sv
// rtl/integrator_arbiter_pkg.sv - shared state type and default parameters for integrator_arbiter
package integrator_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   localparam int NREQ_DEF = 4;
   localparam int BW_DEF   = 8;
   localparam int SW_DEF   = 16;
   localparam int EC_DEF   = 8;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/integrator_arbiter_if.sv
// rtl/integrator_arbiter_if.sv - requester, integrator and result channels of integrator_arbiter
interface integrator_arbiter_if
   import integrator_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int bW   = BW_DEF,
   parameter int sW   = SW_DEF,
   parameter int iW   = id_width(NREQ)
);

   logic [NREQ*bW-1:0] req_d;
   logic [NREQ-1:0]    req_vld;
   logic [NREQ-1:0]    req_rdy;
   logic [bW-1:0]      int_d;
   logic               int_d_vld;
   logic               int_d_rdy;
   logic [sW-1:0]      int_sum;
   logic               int_sum_vld;
   logic               int_sum_rdy;
   logic [sW-1:0]      res_sum;
   logic [iW-1:0]      res_id;
   logic               res_vld;
   logic               res_rdy;
   logic [iW-1:0]      grant_id;
   logic               busy;
   logic               proto_err;

   // The arbiter is the slave side; sources, integrator and result sink form the master side.
   modport slave (
      input  req_d, req_vld, int_d_rdy, int_sum, int_sum_vld, res_rdy,
      output req_rdy, int_d, int_d_vld, int_sum_rdy, res_sum, res_id, res_vld,
      output grant_id, busy, proto_err
   );

   modport master (
      output req_d, req_vld, int_d_rdy, int_sum, int_sum_vld, res_rdy,
      input  req_rdy, int_d, int_d_vld, int_sum_rdy, res_sum, res_id, res_vld,
      input  grant_id, busy, proto_err
   );

endinterface

// File: rtl/integrator_arbiter_rr_pick.sv
// rtl/integrator_arbiter_rr_pick.sv - rotating-priority picker, first request after last grant wins
module rr_pick #(
   parameter int NREQ = 4,
   parameter int iW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [iW-1:0]   last_i,
   output logic [iW-1:0]   gnt_o,
   output logic            any_o
);

   logic [iW-1:0] idx;

   // Scan from the farthest offset down so the nearest requester after last_i overwrites.
   always_comb begin
      gnt_o = '0;
      idx   = '0;
      any_o = |req_i;
      for (int off = NREQ; off >= 1; off--) begin
         idx = iW'((int'(last_i) + off) % NREQ);
         if (req_i[idx]) begin
            gnt_o = idx;
         end
      end
   end

endmodule

// File: rtl/integrator_arbiter.sv
// rtl/integrator_arbiter.sv - round-robin frame arbiter sharing one integrator between requesters
module integrator_arbiter
   import integrator_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int bW   = BW_DEF,
   parameter int sW   = SW_DEF,
   parameter int eC   = EC_DEF,
   parameter int iW   = id_width(NREQ),
   parameter int cW   = $clog2(eC + 1)
) (
   input logic clk,
   input logic rst,
   integrator_arbiter_if.slave bus
);

   arb_state_e    state_q, state_d;
   logic [cW-1:0] cnt_q, cnt_d;
   logic [iW-1:0] last_q, last_d;
   logic [iW-1:0] grant_q, grant_d;
   logic          err_q, err_d;
   logic          post_drain_q, post_drain_d;
   logic          stall_q, stall_d;

   logic [iW-1:0] pick;
   logic          any_req;
   logic          beat;
   logic          stall;
   logic [cW-1:0] cnt_inc;

   rr_pick #(
      .NREQ (NREQ),
      .iW   (iW)
   ) u_pick (
      .req_i  (bus.req_vld),
      .last_i (last_q),
      .gnt_o  (pick),
      .any_o  (any_req)
   );

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_q       <= iW'(NREQ - 1);
         grant_q      <= '0;
         err_q        <= 1'b0;
         post_drain_q <= 1'b0;
         stall_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         grant_q      <= grant_d;
         err_q        <= err_d;
         post_drain_q <= post_drain_d;
         stall_q      <= stall_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      last_d          = last_q;
      grant_d         = grant_q;
      err_d           = err_q;
      post_drain_d    = post_drain_q;
      stall_d         = 1'b0;
      beat            = 1'b0;
      stall           = 1'b0;
      bus.req_rdy     = '0;
      bus.int_d       = '0;
      bus.int_d_vld   = 1'b0;
      bus.int_sum_rdy = 1'b0;
      bus.res_sum     = '0;
      bus.res_id      = '0;
      bus.res_vld     = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick;
               state_d = ACCUM;
            end
         end

         ACCUM: begin
            bus.int_d            = bus.req_d[grant_q*bW +: bW];
            bus.int_d_vld        = bus.req_vld[grant_q];
            bus.req_rdy[grant_q] = bus.int_d_rdy;
            beat  = bus.int_d_vld && bus.int_d_rdy;
            // An integrator that just handed back a sum should take the next frame promptly.
            stall = post_drain_q && bus.int_d_vld && !bus.int_d_rdy;
            if (beat) begin
               post_drain_d = 1'b0;
               if (cnt_inc == cW'(eC)) begin
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            if (bus.int_sum_vld || (stall && stall_q)) begin
               err_d = 1'b1;
            end
            stall_d = stall;
         end

         DRAIN: begin
            bus.res_sum     = bus.int_sum;
            bus.res_vld     = bus.int_sum_vld;
            bus.res_id      = grant_q;
            bus.int_sum_rdy = bus.res_rdy;
            if (bus.int_sum_vld && bus.res_rdy) begin
               last_d       = grant_q;
               post_drain_d = 1'b1;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.grant_id  = grant_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.proto_err = err_q;

endmodule

// File: tb/tb_integrator_arbiter.sv
// tb/tb_integrator_arbiter.sv - directed bench for integrator_arbiter with a frame-level reference model
module tb_integrator_arbiter;
   import integrator_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int BW   = 8;
   localparam int SW   = 16;
   localparam int EC   = 8;
   localparam int IW   = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   integrator_arbiter_if #(.NREQ(NREQ), .bW(BW), .sW(SW), .iW(IW)) bus ();

   integrator_arbiter #(
      .NREQ (NREQ),
      .bW   (BW),
      .sW   (SW),
      .eC   (EC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int id;
      int sum;
   } exp_t;

   int   nchk = 0;
   int   nerr = 0;
   int   nres = 0;
   exp_t expq[$];
   int   base[NREQ];
   int   step[NREQ];
   int   scnt[NREQ];
   logic force_sum;

   // Integrator stand-in: takes eC samples, offers the sum until it is accepted.
   logic [SW-1:0] acc_q;
   int            n_q;

   assign bus.int_d_rdy   = (n_q < EC);
   assign bus.int_sum_vld = (n_q == EC) || force_sum;
   assign bus.int_sum     = acc_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         n_q   <= 0;
      end else if (bus.int_d_vld && bus.int_d_rdy) begin
         acc_q <= acc_q + SW'(bus.int_d);
         n_q   <= n_q + 1;
      end else if (n_q == EC && bus.int_sum_rdy) begin
         acc_q <= '0;
         n_q   <= 0;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_model(input int last, input logic [NREQ-1:0] vld);
      int v;
      int idx;
      v = int'(vld);
      for (int i = 1; i <= NREQ; i++) begin
         idx = (last + i) % NREQ;
         if (((v >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   task automatic refresh_data();
      for (int k = 0; k < NREQ; k++) bus.req_d[k*BW +: BW] = BW'(base[k] + step[k] * scnt[k]);
   endtask

   task automatic tick();
      logic [NREQ-1:0] hs;
      @(negedge clk);
      hs = bus.req_vld & bus.req_rdy;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) if (hs[k]) scnt[k]++;
      refresh_data();
   endtask

   task automatic wait_results(input int n);
      int target;
      int b;
      target = nres + n;
      b = 0;
      while (nres < target && b < 200) begin
         tick();
         b++;
      end
      if (nres < target) check("result_timeout", nres, target);
   endtask

   task automatic reset_assert();
      rst         = 1'b1;
      bus.req_vld = '0;
      bus.res_rdy = 1'b1;
      force_sum   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         base[k] = 0;
         step[k] = 0;
         scnt[k] = 0;
      end
      refresh_data();
   endtask

   task automatic reset_release();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_rdy"}, bus.req_rdy, 0);
      check({tag, "_int_d"}, bus.int_d, 0);
      check({tag, "_int_d_vld"}, bus.int_d_vld, 0);
      check({tag, "_int_sum_rdy"}, bus.int_sum_rdy, 0);
      check({tag, "_res_sum"}, bus.res_sum, 0);
      check({tag, "_res_id"}, bus.res_id, 0);
      check({tag, "_res_vld"}, bus.res_vld, 0);
      check({tag, "_grant_id"}, bus.grant_id, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_proto_err"}, bus.proto_err, 0);
   endtask

   // Frame-level model: a frame is accumulating until eC samples reached the integrator.
   int              mlast  = NREQ - 1;
   int              mbeats = 0;
   logic            pbusy  = 1'b0;
   logic [NREQ-1:0] pvld   = '0;
   logic            phold  = 1'b0;
   logic [SW-1:0]   hsum;
   logic [IW-1:0]   hid;
   int              g;
   exp_t            e;

   always @(negedge clk) begin
      if (rst) begin
         mlast  = NREQ - 1;
         mbeats = 0;
         pbusy  = 1'b0;
         phold  = 1'b0;
         pvld   = bus.req_vld;
      end else begin
         g = int'(bus.grant_id);
         if (bus.busy && !pbusy) begin
            check("grant_order", g, rr_model(mlast, pvld));
            mbeats = 0;
         end
         if (!bus.busy) begin
            check("idle_req_rdy", bus.req_rdy, 0);
            check("idle_int_d_vld", bus.int_d_vld, 0);
            check("idle_res_vld", bus.res_vld, 0);
            check("idle_int_sum_rdy", bus.int_sum_rdy, 0);
         end else if (mbeats < EC) begin
            check("accum_other_rdy", bus.req_rdy & ~(NREQ'(1) << g), 0);
            check("accum_own_rdy", (bus.req_rdy >> g) & 1, bus.int_d_rdy);
            check("accum_int_d_vld", bus.int_d_vld, (bus.req_vld >> g) & 1);
            check("accum_int_d", bus.int_d, BW'(bus.req_d >> (g * BW)));
            check("accum_res_vld", bus.res_vld, 0);
            check("accum_int_sum_rdy", bus.int_sum_rdy, 0);
         end else begin
            check("drain_req_rdy", bus.req_rdy, 0);
            check("drain_int_d_vld", bus.int_d_vld, 0);
            check("drain_res_vld", bus.res_vld, bus.int_sum_vld);
            check("drain_res_id", bus.res_id, g);
            check("drain_int_sum_rdy", bus.int_sum_rdy, bus.res_rdy);
            if (bus.res_vld) check("drain_res_sum", bus.res_sum, bus.int_sum);
         end
         if (phold) begin
            check("hold_res_vld", bus.res_vld, 1);
            check("hold_res_sum", bus.res_sum, hsum);
            check("hold_res_id", bus.res_id, hid);
         end
         phold = bus.res_vld && !bus.res_rdy;
         hsum  = bus.res_sum;
         hid   = bus.res_id;
         if (bus.res_vld && bus.res_rdy) begin
            if (expq.size() == 0) begin
               check("unexpected_result", bus.res_id, -1);
            end else begin
               e = expq.pop_front();
               check("res_id", bus.res_id, e.id);
               check("res_sum", bus.res_sum, e.sum);
               mlast = e.id;
            end
            nres++;
         end
         if (bus.int_d_vld && bus.int_d_rdy) mbeats++;
         pbusy = bus.busy;
         pvld  = bus.req_vld;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset_assert();
      #1;
      check_zero("reset");
      reset_release();

      // Single requester 2, samples 1..8.
      base[2] = 1; step[2] = 1; refresh_data();
      expq.push_back('{2, 36});
      bus.req_vld = 4'b0100;
      repeat (9) tick();
      check("t1_res_vld", bus.res_vld, 1);
      check("t1_res_sum", bus.res_sum, 36);
      check("t1_res_id", bus.res_id, 2);
      check("t1_busy_drain", bus.busy, 1);
      bus.req_vld = '0;
      tick();
      check("t1_busy_fall", bus.busy, 0);
      check("t1_grant_kept", bus.grant_id, 2);

      // All requesters valid, constant k+1.
      reset_assert();
      reset_release();
      for (int k = 0; k < NREQ; k++) base[k] = k + 1;
      refresh_data();
      expq.push_back('{0, 8});
      expq.push_back('{1, 16});
      expq.push_back('{2, 24});
      expq.push_back('{3, 32});
      expq.push_back('{0, 8});
      bus.req_vld = 4'b1111;
      wait_results(5);
      bus.req_vld = '0;
      repeat (2) tick();

      // Granted requester 1 stalls after 3 beats while requester 0 waits.
      reset_assert();
      reset_release();
      base[1] = 1; step[1] = 1; base[0] = 2; refresh_data();
      expq.push_back('{1, 36});
      expq.push_back('{0, 16});
      bus.req_vld = 4'b0010;
      tick();
      bus.req_vld = 4'b0011;
      repeat (3) tick();
      bus.req_vld = 4'b0001;
      repeat (5) tick();
      check("t3_grant_locked", bus.grant_id, 1);
      check("t3_busy", bus.busy, 1);
      check("t3_int_d_vld", bus.int_d_vld, 0);
      bus.req_vld = 4'b0011;
      wait_results(2);
      bus.req_vld = '0;
      repeat (2) tick();

      // Result back-pressure in DRAIN.
      reset_assert();
      reset_release();
      base[3] = 7; base[0] = 3; refresh_data();
      expq.push_back('{3, 56});
      expq.push_back('{0, 24});
      bus.res_rdy = 1'b0;
      bus.req_vld = 4'b1000;
      for (int b = 0; b < 30 && !bus.res_vld; b++) tick();
      check("t4_drain_reached", bus.res_vld, 1);
      bus.req_vld = 4'b1001;
      repeat (6) begin
         tick();
         check("t4_res_vld", bus.res_vld, 1);
         check("t4_res_sum", bus.res_sum, 56);
         check("t4_res_id", bus.res_id, 3);
         check("t4_int_sum_rdy", bus.int_sum_rdy, 0);
         check("t4_grant", bus.grant_id, 3);
      end
      bus.res_rdy = 1'b1;
      wait_results(2);
      bus.req_vld = '0;
      repeat (2) tick();

      // Reset after 4 beats discards the frame.
      reset_assert();
      reset_release();
      base[0] = 1; step[0] = 1; refresh_data();
      bus.req_vld = 4'b0001;
      repeat (5) tick();
      check("t5_busy_before", bus.busy, 1);
      rst = 1'b1;
      #1;
      check_zero("t5_abort");
      check("t5_no_stale_expect", expq.size(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      scnt[0] = 0; refresh_data();
      expq.push_back('{0, 36});
      wait_results(1);
      bus.req_vld = '0;
      repeat (2) tick();

      // Early integrator sum inside ACCUM.
      reset_assert();
      reset_release();
      base[2] = 1; refresh_data();
      expq.push_back('{2, 8});
      bus.req_vld = 4'b0100;
      repeat (6) tick();
      check("t6_err_clear", bus.proto_err, 0);
      force_sum = 1'b1;
      tick();
      check("t6_err_set", bus.proto_err, 1);
      force_sum = 1'b0;
      wait_results(1);
      bus.req_vld = '0;
      repeat (3) tick();
      check("t6_err_sticky", bus.proto_err, 1);
      reset_assert();
      #1;
      check("t6_err_reset", bus.proto_err, 0);
      reset_release();

      check("expect_queue_empty", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
